id_ie_pipe_reg: RTL and testbench

//  ID/IE pipeline register, directly downstream of the stall/flush muxing stage.

---
 rtl/id_ie_pipe_reg.sv | 190 +++++++++++++++++++
 tb/tb_id_ie_pipe_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ie_pipe_reg.sv
// ID/IE pipeline register with a halt-drain FSM and saturating
// bubble/flush performance counters.
//
// Control semantics: stall and flush arrive already applied to the
// ID_*_sf bundle by the upstream mux stage. This block only records
// whether the captured slot is real (IE_valid_out) and counts the event.
// There is no valid/ready back-pressure on this stage: a new slot is
// captured on every rising edge.
//
// Once a valid halt sits in IE, the FSM stops issue. It loads bubbles
// for DRAIN_CYCLES edges so that MEM and WB can retire, then parks in
// HALTED with halted=1 until reset.
module id_ie_pipe_reg #(
  parameter int          DRAIN_CYCLES = 2,
  parameter int          CNT_W        = 16,
  parameter logic [15:0] NOP_INSTR    = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      ID_ctrl_sf,
  input  logic [15:0]      ID_Instr_sf,
  input  logic [15:0]      ID_read1data_sf,
  input  logic [15:0]      ID_read2data_sf,
  input  logic [15:0]      ID_sign_ext_sf,
  input  logic [15:0]      ID_pc_2_w_sf,
  input  logic             stall,
  input  logic             flush,
  output logic [14:0]      IE_ctrl_out,
  output logic [15:0]      IE_Instr_out,
  output logic [15:0]      IE_read1data_out,
  output logic [15:0]      IE_read2data_out,
  output logic [15:0]      IE_sign_ext_out,
  output logic [15:0]      IE_pc_2_w_out,
  output logic             IE_valid_out,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state_o
);

  // Control bundle bit positions, MSB..LSB:
  // {Branch,ALUsrc,memWrite,memRead,memToReg,noOp,jmp,jumpType,
  //  regWrite,halt,instrType[1:0],writereg[2:0]}
  localparam int BIT_BRANCH   = 14;
  localparam int BIT_MEMWRITE = 12;
  localparam int BIT_MEMREAD  = 11;
  localparam int BIT_NOOP     = 9;
  localparam int BIT_REGWRITE = 6;
  localparam int BIT_HALT     = 5;

  localparam int DC_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DC_W-1:0]   drain_q, drain_d;
  logic [14:0]       ctrl_q, ctrl_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       rd1_q, rd1_d;
  logic [15:0]       rd2_q, rd2_d;
  logic [15:0]       sext_q, sext_d;
  logic [15:0]       pc2_q, pc2_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  logic [14:0]       bubble_ctrl;
  logic              load_bubble;

  // Bubble control word: only noOp set; side-effect bits held low.
  always_comb begin
    bubble_ctrl               = '0;
    bubble_ctrl[BIT_NOOP]     = 1'b1;
    bubble_ctrl[BIT_REGWRITE] = 1'b0;
    bubble_ctrl[BIT_MEMWRITE] = 1'b0;
    bubble_ctrl[BIT_MEMREAD]  = 1'b0;
    bubble_ctrl[BIT_BRANCH]   = 1'b0;
  end

  // Next-state, next-slot and counter logic.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halted_d    = halted_q;
    bcnt_d      = bcnt_q;
    fcnt_d      = fcnt_q;
    load_bubble = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (flush) begin
          if (fcnt_q != {CNT_W{1'b1}}) fcnt_d = fcnt_q + CNT_W'(1);
        end else if (stall) begin
          if (bcnt_q != {CNT_W{1'b1}}) bcnt_d = bcnt_q + CNT_W'(1);
        end
        // A real halt in IE wins over a simultaneous flush.
        if (ctrl_q[BIT_HALT] && valid_q) begin
          state_d     = ST_DRAIN;
          drain_d     = DRAIN_LOAD;
          load_bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        load_bubble = 1'b1;
        if (drain_q == '0) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_d = drain_q - DC_W'(1);
        end
      end
      ST_HALTED: begin
        load_bubble = 1'b1;
        halted_d    = 1'b1;
      end
      default: begin
        state_d     = ST_RUN;
        load_bubble = 1'b1;
      end
    endcase

    if (load_bubble) begin
      ctrl_d  = bubble_ctrl;
      instr_d = NOP_INSTR;
      rd1_d   = '0;
      rd2_d   = '0;
      sext_d  = '0;
      pc2_d   = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = ID_ctrl_sf;
      instr_d = ID_Instr_sf;
      rd1_d   = ID_read1data_sf;
      rd2_d   = ID_read2data_sf;
      sext_d  = ID_sign_ext_sf;
      pc2_d   = ID_pc_2_w_sf;
      valid_d = !stall && !flush;
    end
  end

  // State, pipeline slot and counter registers; reset loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      ctrl_q   <= bubble_ctrl;
      instr_q  <= NOP_INSTR;
      rd1_q    <= '0;
      rd2_q    <= '0;
      sext_q   <= '0;
      pc2_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      bcnt_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      ctrl_q   <= ctrl_d;
      instr_q  <= instr_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      sext_q   <= sext_d;
      pc2_q    <= pc2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      bcnt_q   <= bcnt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign IE_ctrl_out      = ctrl_q;
  assign IE_Instr_out     = instr_q;
  assign IE_read1data_out = rd1_q;
  assign IE_read2data_out = rd2_q;
  assign IE_sign_ext_out  = sext_q;
  assign IE_pc_2_w_out    = pc2_q;
  assign IE_valid_out     = valid_q;
  assign halted           = halted_q;
  assign bubble_cnt       = bcnt_q;
  assign flush_cnt        = fcnt_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_id_ie_pipe_reg.sv
// Directed bench for id_ie_pipe_reg: table of pass-through vectors plus
// hand-written halt/drain/reset/saturation sequences.
module tb_id_ie_pipe_reg;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [14:0] BUB_CTRL = 15'h0200;
  localparam logic [14:0] HALT_CTRL = 15'h0020;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [14:0] ctrl_i;
  logic [15:0] instr_i, r1_i, r2_i, se_i, pc_i;
  logic        stall_i, flush_i;

  logic [14:0] ie_ctrl;
  logic [15:0] ie_instr, ie_r1, ie_r2, ie_se, ie_pc;
  logic        ie_valid, halted;
  logic [15:0] bcnt, fcnt;
  logic [1:0]  state;

  // Second instance with narrow counters for the saturation check.
  logic        rst4, stall4;
  logic [14:0] ie_ctrl4;
  logic [15:0] ie_instr4, ie_r14, ie_r24, ie_se4, ie_pc4;
  logic        ie_valid4, halted4;
  logic [3:0]  bcnt4, fcnt4;
  logic [1:0]  state4;

  id_ie_pipe_reg #(.DRAIN_CYCLES(2), .CNT_W(16), .NOP_INSTR(16'h0800)) u_dut (
    .clk(clk), .rst(rst),
    .ID_ctrl_sf(ctrl_i), .ID_Instr_sf(instr_i),
    .ID_read1data_sf(r1_i), .ID_read2data_sf(r2_i),
    .ID_sign_ext_sf(se_i), .ID_pc_2_w_sf(pc_i),
    .stall(stall_i), .flush(flush_i),
    .IE_ctrl_out(ie_ctrl), .IE_Instr_out(ie_instr),
    .IE_read1data_out(ie_r1), .IE_read2data_out(ie_r2),
    .IE_sign_ext_out(ie_se), .IE_pc_2_w_out(ie_pc),
    .IE_valid_out(ie_valid), .halted(halted),
    .bubble_cnt(bcnt), .flush_cnt(fcnt), .dbg_state_o(state)
  );

  id_ie_pipe_reg #(.DRAIN_CYCLES(2), .CNT_W(4), .NOP_INSTR(16'h0800)) u_dut4 (
    .clk(clk), .rst(rst4),
    .ID_ctrl_sf(ctrl_i), .ID_Instr_sf(instr_i),
    .ID_read1data_sf(r1_i), .ID_read2data_sf(r2_i),
    .ID_sign_ext_sf(se_i), .ID_pc_2_w_sf(pc_i),
    .stall(stall4), .flush(1'b0),
    .IE_ctrl_out(ie_ctrl4), .IE_Instr_out(ie_instr4),
    .IE_read1data_out(ie_r14), .IE_read2data_out(ie_r24),
    .IE_sign_ext_out(ie_se4), .IE_pc_2_w_out(ie_pc4),
    .IE_valid_out(ie_valid4), .halted(halted4),
    .bubble_cnt(bcnt4), .flush_cnt(fcnt4), .dbg_state_o(state4)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [14:0] c, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] s, input logic [15:0] p,
                       input logic st, input logic fl);
    ctrl_i = c; instr_i = ins; r1_i = a; r2_i = b; se_i = s; pc_i = p;
    stall_i = st; flush_i = fl;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_ctrl"},  32'(ie_ctrl), 32'(BUB_CTRL));
    chk({tag, "_instr"}, 32'(ie_instr), 32'h0800);
    chk({tag, "_r1"},    32'(ie_r1), 32'h0);
    chk({tag, "_pc"},    32'(ie_pc), 32'h0);
    chk({tag, "_valid"}, 32'(ie_valid), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [14:0] ctrl;
    logic [15:0] instr, r1, r2, se, pc;
    logic        st, fl;
    logic        exp_valid;
    logic [15:0] exp_b, exp_f;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{15'h0043, 16'h4123, 16'h0011, 16'h0022, 16'hFFF0, 16'h0002, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    vecs[1] = '{15'h2C05, 16'h8A45, 16'h1234, 16'h5678, 16'h0007, 16'h0004, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    vecs[2] = '{15'h0200, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[3] = '{15'h0200, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0};
    vecs[4] = '{15'h0200, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0};
    vecs[5] = '{15'h0200, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b1, 1'b0, 16'd3, 16'd1};
    vecs[6] = '{15'h0200, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
    vecs[7] = '{15'h7FDF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'd3, 16'd2};
    vecs[8] = '{15'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd3, 16'd2};

    rst = 1'b1; rst4 = 1'b1; stall4 = 1'b0;
    drive(15'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(); step();

    // Reset state
    chk_bubble("rst");
    chk("rst_r2", 32'(ie_r2), 32'h0);
    chk("rst_se", 32'(ie_se), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_bcnt", 32'(bcnt), 32'h0);
    chk("rst_fcnt", 32'(fcnt), 32'h0);
    chk("rst_state", 32'(state), 32'(S_RUN));
    rst = 1'b0;

    // Table: pass-through, stall bubbles, flush priority
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ctrl, vecs[i].instr, vecs[i].r1, vecs[i].r2, vecs[i].se, vecs[i].pc,
            vecs[i].st, vecs[i].fl);
      step();
      chk($sformatf("v%0d_ctrl", i),  32'(ie_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_instr", i), 32'(ie_instr), 32'(vecs[i].instr));
      chk($sformatf("v%0d_r1", i),    32'(ie_r1), 32'(vecs[i].r1));
      chk($sformatf("v%0d_r2", i),    32'(ie_r2), 32'(vecs[i].r2));
      chk($sformatf("v%0d_se", i),    32'(ie_se), 32'(vecs[i].se));
      chk($sformatf("v%0d_pc", i),    32'(ie_pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d_valid", i), 32'(ie_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_bcnt", i),  32'(bcnt), 32'(vecs[i].exp_b));
      chk($sformatf("v%0d_fcnt", i),  32'(fcnt), 32'(vecs[i].exp_f));
    end

    // Halt bit on a stalled (invalid) slot must not start a drain.
    drive(HALT_CTRL, 16'h6000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    chk("ihalt_valid", 32'(ie_valid), 32'h0);
    chk("ihalt_bcnt", 32'(bcnt), 32'd4);
    drive(15'h0043, 16'h4321, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 1'b0, 1'b0);
    step();
    chk("ihalt_state", 32'(state), 32'(S_RUN));
    chk("ihalt_instr", 32'(ie_instr), 32'h4321);
    chk("ihalt_valid2", 32'(ie_valid), 32'h1);

    // Valid halt: drain two cycles, halted three edges after load.
    drive(HALT_CTRL, 16'h6000, 16'h0, 16'h0, 16'h0, 16'h0012, 1'b0, 1'b0);
    step();
    chk("halt_ctrl", 32'(ie_ctrl), 32'(HALT_CTRL));
    chk("halt_valid", 32'(ie_valid), 32'h1);
    drive(15'h7FDF, 16'h1234, 16'hAAAA, 16'h5555, 16'h1111, 16'h0014, 1'b0, 1'b0);
    step();
    chk_bubble("drain1");
    chk("drain1_state", 32'(state), 32'(S_DRAIN));
    chk("drain1_halted", 32'(halted), 32'h0);
    step();
    chk_bubble("drain2");
    chk("drain2_state", 32'(state), 32'(S_DRAIN));
    chk("drain2_halted", 32'(halted), 32'h0);
    step();
    chk("halt3_halted", 32'(halted), 32'h1);
    chk("halt3_state", 32'(state), 32'(S_HALTED));
    chk_bubble("halt3");
    drive(15'h7FDF, 16'h1234, 16'hAAAA, 16'h5555, 16'h1111, 16'h0014, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_halted", i), 32'(halted), 32'h1);
      chk($sformatf("hold%0d_instr", i), 32'(ie_instr), 32'h0800);
      chk($sformatf("hold%0d_bcnt", i), 32'(bcnt), 32'd4);
      chk($sformatf("hold%0d_fcnt", i), 32'(fcnt), 32'd2);
    end

    // Reset from HALTED, then reset again one cycle into DRAIN.
    drive(15'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rh_halted", 32'(halted), 32'h0);
    chk("rh_state", 32'(state), 32'(S_RUN));
    chk("rh_bcnt", 32'(bcnt), 32'h0);
    drive(HALT_CTRL, 16'h6000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    drive(15'h0043, 16'h4123, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 1'b0);
    step();
    chk("rd_state_pre", 32'(state), 32'(S_DRAIN));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rd_halted", 32'(halted), 32'h0);
    chk("rd_state", 32'(state), 32'(S_RUN));
    chk_bubble("rd");
    chk("rd_fcnt", 32'(fcnt), 32'h0);

    // Halt in IE together with flush: drain wins, flush still counted.
    drive(HALT_CTRL, 16'h6000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    drive(15'h0043, 16'h4123, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1, 1'b1);
    step();
    chk("hf_state", 32'(state), 32'(S_DRAIN));
    chk("hf_fcnt", 32'(fcnt), 32'd1);
    chk("hf_bcnt", 32'(bcnt), 32'd0);
    chk_bubble("hf");
    drive(15'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(); step();
    chk("hf_halted", 32'(halted), 32'h1);
    chk("hf_fcnt_hold", 32'(fcnt), 32'd1);

    // Narrow-counter saturation.
    step();
    chk("sat_rst", 32'(bcnt4), 32'h0);
    rst4 = 1'b0; stall4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat%0d", i), 32'(bcnt4), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    stall4 = 1'b0;
    step();
    chk("sat_hold", 32'(bcnt4), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
